hvac_zone_ctrl: RTL and testbench
=================================

# hvac_zone_ctrl

Multi-zone heating/cooling controller: a parametrised successor to the single-zone IDLE/HEATING/COOLING thermostat. It runs one independent state machine per zone on signed fixed-point temperatures, with hysteresis, minimum-run and lockout timers, a global mode select and sticky over-limit faults. It sits between the sampled sensor front end and the per-zone heater/cooler drive outputs.

## Interface
- ZONES, 4, number of independent zones (1..16)
- TW, 12, temperature width, signed two's complement, 4 fractional bits
- HYST, 8, hysteresis in LSBs (0.5 °C), unsigned, must be < 2^(TW-1)
- MIN_RUN, 6, minimum sample ticks a heat/cool run lasts, ≥ 1
- LOCKOUT, 10, sample ticks all outputs are held off after any run, ≥ 1
- TMAX, 12'sd1280, over-temperature limit (80 °C)
- TMIN, -12'sd160, under-temperature limit (-10 °C)
- clock  in  1  system clock, all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state
- mode  in  2  global mode: 00 off, 01 heat-only, 10 cool-only, 11 auto
- temp_valid  in  1  one-cycle strobe; temp and setpoint sampled this cycle (one "tick")
- temp  in  ZONES*TW  measured temperatures, zone z at [z*TW +: TW]
- setpoint  in  ZONES*TW  target temperatures, same packing
- fault_clr  in  1  clears all sticky fault bits
- heat  out  ZONES  heater drive per zone
- cool  out  ZONES  cooler drive per zone
- zone_state  out  2*ZONES  per-zone state: 00 IDLE, 01 HEATING, 10 COOLING, 11 LOCKOUT
- fault  out  ZONES  sticky over/under-limit fault per zone

## Operation
- Per zone: err = temp − setpoint, computed at TW+1 bits with sign extension (no overflow). The timer tcnt has width clog2(max(MIN_RUN, LOCKOUT)+1) and advances only on temp_valid.
- All transitions are evaluated only in cycles with temp_valid=1. Without temp_valid, state, tcnt and fault hold.
- IDLE: heat=cool=0, tcnt=0.
  - If mode∈{01,11}, err < −HYST and no fault → HEATING.
  - Else if mode∈{10,11}, err > HYST and no fault → COOLING.
  - Else stay.
- HEATING: heat=1, and tcnt increments on each tick.
  - → LOCKOUT (tcnt←0) when err ≥ 0 and tcnt ≥ MIN_RUN−1.
  - → LOCKOUT immediately, overriding MIN_RUN, if mode∈{00,10}, or if temp > TMAX.
- COOLING: cool=1, and tcnt increments on each tick.
  - → LOCKOUT when err ≤ 0 and tcnt ≥ MIN_RUN−1.
  - → LOCKOUT immediately if mode∈{00,01}, or if temp < TMIN.
- LOCKOUT: heat=cool=0, and tcnt increments on each tick.
  - → IDLE (tcnt←0) on the tick where tcnt = LOCKOUT−1.
  - Mode changes do not shorten the lockout.
- Fault: on a tick in any state, temp > TMAX or temp < TMIN sets fault[z].
  - The bit is sticky and blocks entry to HEATING/COOLING.
  - fault_clr clears all bits in the next cycle. If fault_clr and a new violation occur in the same tick, set wins.
- heat[z] and cool[z] are never both 1. Both outputs decode directly from the state register, so they are glitch-free.
- Zones are fully independent. Nothing is shared except mode, temp_valid and fault_clr.

## Timing
- Reset (asynchronous assert):
  - All zones go to IDLE, tcnt=0.
  - heat=0, cool=0, zone_state=0, fault=0, immediately and without a clock.
- Deassertion is synchronised externally. The first tick after release is evaluated normally.
- Latency: temp_valid in cycle N → state, heat, cool and fault updated at the rising edge ending cycle N, visible in cycle N+1.
- Run length: a run lasts at least MIN_RUN ticks unless the mode or a limit aborts it.
- Lockout: lasts exactly LOCKOUT ticks.
- Back-to-back temp_valid on consecutive cycles is legal. Each cycle counts as one tick.
- Reset mid-run: the outputs drop at once and the lockout is not honoured.

## Test plan
- Heat cycle: ZONES=4, mode=11, zone0 setpoint=320 (20 °C), temp=300 → heat[0]=1 the cycle after the first tick. Then temp=321 on tick 2 → heat stays 1 until tick 6 (MIN_RUN), then LOCKOUT for 10 ticks, then IDLE; zone_state[1:0] sequence 00→01→11→00.
- Hysteresis: setpoint=320, temp=313..327 → zone stays IDLE. temp=311 → HEATING. temp=329 from IDLE → COOLING.
- Mode abort: zone1 COOLING at tick 2 with mode=11, then mode=01 on tick 3 → cool[1]=0 in the next cycle, LOCKOUT, and no HEATING before 10 ticks, even with temp=200.
- Fault: zone2 temp=1290 while HEATING → heat[2]=0, fault[2]=1, LOCKOUT. After lockout, temp=200 keeps heat[2]=0 until fault_clr; the next tick after clear → HEATING. fault_clr on the same tick as temp=1290 → fault stays 1.
- Independence/reset: zones 0–3 in HEATING, COOLING, LOCKOUT and IDLE simultaneously. Assert reset asynchronously between clock edges → all outputs go to 0 before the next edge, and all zones are IDLE after release.
- No-tick hold: temp_valid=0 for 50 cycles with err=−200 → no state change, tcnt frozen.

Source files
------------

// File: rtl/hvac_zone_ctrl.sv
// hvac_zone_ctrl: multi-zone heat/cool controller. Each zone runs its own
// IDLE/HEATING/COOLING/LOCKOUT machine on signed fixed-point temperatures
// (4 fractional bits), with hysteresis, minimum-run and lockout timers,
// a global mode select and sticky over/under-limit faults.
module hvac_zone_ctrl #(
    parameter int ZONES   = 4,
    parameter int TW      = 12,
    parameter int HYST    = 8,
    parameter int MIN_RUN = 6,
    parameter int LOCKOUT = 10,
    parameter logic signed [TW-1:0] TMAX = 12'sd1280,
    parameter logic signed [TW-1:0] TMIN = -12'sd160
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            mode,
    input  logic                  temp_valid,
    input  logic [ZONES*TW-1:0]   temp,
    input  logic [ZONES*TW-1:0]   setpoint,
    input  logic                  fault_clr,
    output logic [ZONES-1:0]      heat,
    output logic [ZONES-1:0]      cool,
    output logic [2*ZONES-1:0]    zone_state,
    output logic [ZONES-1:0]      fault
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HEAT = 2'b01,
        ST_COOL = 2'b10,
        ST_LOCK = 2'b11
    } state_t;

    // One timer serves both the run and lockout phases, so it must reach
    // the larger of the two terminal counts.
    localparam int CNT_MAX = (MIN_RUN > LOCKOUT) ? MIN_RUN : LOCKOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0]        RUN_LAST  = CW'(MIN_RUN - 1);
    localparam logic [CW-1:0]        LOCK_LAST = CW'(LOCKOUT - 1);
    localparam logic signed [TW:0]   HYST_POS  = (TW+1)'(HYST);
    localparam logic signed [TW:0]   HYST_NEG  = -HYST_POS;
    localparam logic signed [TW:0]   ERR_ZERO  = '0;

    // mode[0] enables heating (01/11), mode[1] enables cooling (10/11).
    logic heat_en;
    logic cool_en;
    assign heat_en = mode[0];
    assign cool_en = mode[1];

    for (genvar z = 0; z < ZONES; z++) begin : g_zone
        state_t                 state_q;
        state_t                 state_d;
        logic [CW-1:0]          tcnt_q;
        logic [CW-1:0]          tcnt_d;
        logic                   fault_q;
        logic                   fault_d;
        logic signed [TW-1:0]   t;
        logic signed [TW-1:0]   s;
        logic signed [TW:0]     err;
        logic                   over;
        logic                   under;
        logic                   viol;
        logic                   blocked;

        assign t   = temp[z*TW +: TW];
        assign s   = setpoint[z*TW +: TW];
        // One extra bit so the difference of two full-range values cannot wrap.
        assign err = {t[TW-1], t} - {s[TW-1], s};

        assign over    = (t > TMAX);
        assign under   = (t < TMIN);
        assign viol    = over | under;
        // A violation seen on this very tick also prevents starting a run.
        assign blocked = fault_q | viol;

        // Next-state, timer and sticky-fault logic; everything moves only on a tick.
        always_comb begin
            state_d = state_q;
            tcnt_d  = tcnt_q;
            fault_d = fault_q;
            if (fault_clr) begin
                fault_d = 1'b0;
            end
            if (temp_valid) begin
                if (viol) begin
                    fault_d = 1'b1;
                end
                case (state_q)
                    ST_IDLE: begin
                        tcnt_d = '0;
                        if (heat_en && (err < HYST_NEG) && !blocked) begin
                            state_d = ST_HEAT;
                        end else if (cool_en && (err > HYST_POS) && !blocked) begin
                            state_d = ST_COOL;
                        end
                    end
                    ST_HEAT: begin
                        if (!heat_en || over) begin
                            state_d = ST_LOCK;
                            tcnt_d  = '0;
                        end else if ((err >= ERR_ZERO) && (tcnt_q >= RUN_LAST)) begin
                            state_d = ST_LOCK;
                            tcnt_d  = '0;
                        end else begin
                            tcnt_d = tcnt_q + 1'b1;
                        end
                    end
                    ST_COOL: begin
                        if (!cool_en || under) begin
                            state_d = ST_LOCK;
                            tcnt_d  = '0;
                        end else if ((err <= ERR_ZERO) && (tcnt_q >= RUN_LAST)) begin
                            state_d = ST_LOCK;
                            tcnt_d  = '0;
                        end else begin
                            tcnt_d = tcnt_q + 1'b1;
                        end
                    end
                    default: begin
                        // Lockout ignores mode: it always runs its full length.
                        if (tcnt_q == LOCK_LAST) begin
                            state_d = ST_IDLE;
                            tcnt_d  = '0;
                        end else begin
                            tcnt_d = tcnt_q + 1'b1;
                        end
                    end
                endcase
            end
        end

        // Zone state, timer and fault registers with asynchronous clear.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                state_q <= ST_IDLE;
                tcnt_q  <= '0;
                fault_q <= 1'b0;
            end else begin
                state_q <= state_d;
                tcnt_q  <= tcnt_d;
                fault_q <= fault_d;
            end
        end

        // Drives decode straight from the state register: glitch-free and
        // heat/cool mutually exclusive by construction.
        assign heat[z]             = (state_q == ST_HEAT);
        assign cool[z]             = (state_q == ST_COOL);
        assign zone_state[2*z +: 2] = state_q;
        assign fault[z]            = fault_q;
    end

endmodule

// File: tb/tb_hvac_zone_ctrl.sv
// Directed bench for hvac_zone_ctrl: expected zone states/faults are queued
// when each step is driven and popped/compared one time unit after the edge.
module tb_hvac_zone_ctrl;

    localparam int ZONES = 4;
    localparam int TW    = 12;

    localparam logic [1:0] I = 2'b00;
    localparam logic [1:0] H = 2'b01;
    localparam logic [1:0] C = 2'b10;
    localparam logic [1:0] L = 2'b11;

    logic                 clock;
    logic                 reset;
    logic [1:0]           mode;
    logic                 temp_valid;
    logic [ZONES*TW-1:0]  temp;
    logic [ZONES*TW-1:0]  setpoint;
    logic                 fault_clr;
    logic [ZONES-1:0]     heat;
    logic [ZONES-1:0]     cool;
    logic [2*ZONES-1:0]   zone_state;
    logic [ZONES-1:0]     fault;

    typedef struct {
        string      tag;
        int         z;
        logic [1:0] st;
        logic       flt;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    hvac_zone_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .mode       (mode),
        .temp_valid (temp_valid),
        .temp       (temp),
        .setpoint   (setpoint),
        .fault_clr  (fault_clr),
        .heat       (heat),
        .cool       (cool),
        .zone_state (zone_state),
        .fault      (fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic set_temp(input int z, input int t);
        temp[z*TW +: TW] = TW'(t);
    endtask

    task automatic expect4(input string tag, input logic [1:0] s0, input logic [1:0] s1,
                           input logic [1:0] s2, input logic [1:0] s3, input logic [3:0] f);
        logic [1:0] s [4];
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        for (int z = 0; z < 4; z++) begin
            sb.push_back('{tag, z, s[z], f[z]});
        end
    endtask

    task automatic check_now();
        exp_t       e;
        logic [1:0] got_st;
        while (sb.size() > 0) begin
            e      = sb.pop_front();
            got_st = zone_state[2*e.z +: 2];
            checks++;
            assert (got_st === e.st) else begin
                errors++;
                $error("FAIL %s z%0d state got=%b want=%b", e.tag, e.z, got_st, e.st);
            end
            checks++;
            assert (heat[e.z] === (e.st == H)) else begin
                errors++;
                $error("FAIL %s z%0d heat got=%b want=%b", e.tag, e.z, heat[e.z], (e.st == H));
            end
            checks++;
            assert (cool[e.z] === (e.st == C)) else begin
                errors++;
                $error("FAIL %s z%0d cool got=%b want=%b", e.tag, e.z, cool[e.z], (e.st == C));
            end
            checks++;
            assert (fault[e.z] === e.flt) else begin
                errors++;
                $error("FAIL %s z%0d fault got=%b want=%b", e.tag, e.z, fault[e.z], e.flt);
            end
        end
    endtask

    // One tick: temp_valid high for one cycle, then compare queued expectations.
    task automatic tick_exp(input string tag, input logic [1:0] s0, input logic [1:0] s1,
                            input logic [1:0] s2, input logic [1:0] s3, input logic [3:0] f);
        expect4(tag, s0, s1, s2, s3, f);
        temp_valid = 1'b1;
        @(posedge clock);
        #1;
        temp_valid = 1'b0;
        fault_clr  = 1'b0;
        check_now();
    endtask

    task automatic ticks_exp(input int n, input string tag, input logic [1:0] s0,
                             input logic [1:0] s1, input logic [1:0] s2,
                             input logic [1:0] s3, input logic [3:0] f);
        for (int k = 0; k < n; k++) begin
            tick_exp(tag, s0, s1, s2, s3, f);
        end
    endtask

    initial begin
        reset      = 1'b0;
        mode       = 2'b11;
        temp_valid = 1'b0;
        fault_clr  = 1'b0;
        for (int z = 0; z < ZONES; z++) begin
            set_temp(z, 320);
            setpoint[z*TW +: TW] = TW'(320);
        end
        #2 reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        expect4("reset", I, I, I, I, 4'b0000);
        check_now();
        reset = 1'b0;

        // Heat cycle on zone 0, with a 50-cycle no-tick hold mid-run.
        set_temp(0, 300);
        tick_exp("heat_entry", H, I, I, I, 4'b0000);
        set_temp(0, 321);
        ticks_exp(2, "heat_run", H, I, I, I, 4'b0000);
        set_temp(0, 120);
        for (int k = 0; k < 50; k++) begin
            @(posedge clock);
            #1;
            if (k % 10 == 9) begin
                expect4("no_tick_hold", H, I, I, I, 4'b0000);
                check_now();
            end
        end
        set_temp(0, 321);
        ticks_exp(3, "heat_minrun", H, I, I, I, 4'b0000);
        tick_exp("heat_to_lock", L, I, I, I, 4'b0000);
        ticks_exp(9, "lock_hold", L, I, I, I, 4'b0000);
        tick_exp("lock_to_idle", I, I, I, I, 4'b0000);

        // Hysteresis band on zone 0 (boundaries 312 and 328 included).
        for (int t = 312; t <= 328; t++) begin
            set_temp(0, t);
            tick_exp("hyst_band", I, I, I, I, 4'b0000);
        end
        set_temp(0, 311);
        set_temp(3, 329);
        tick_exp("hyst_enter", H, I, I, C, 4'b0000);
        set_temp(0, 320);
        set_temp(3, 320);
        ticks_exp(5, "hyst_run", H, I, I, C, 4'b0000);
        tick_exp("hyst_to_lock", L, I, I, L, 4'b0000);
        ticks_exp(9, "hyst_lock", L, I, I, L, 4'b0000);
        tick_exp("hyst_idle", I, I, I, I, 4'b0000);

        // Mode abort on zone 1.
        set_temp(1, 340);
        ticks_exp(2, "cool_run", I, C, I, I, 4'b0000);
        mode = 2'b01;
        tick_exp("mode_abort", I, L, I, I, 4'b0000);
        set_temp(1, 200);
        ticks_exp(9, "abort_lock", I, L, I, I, 4'b0000);
        tick_exp("abort_idle", I, I, I, I, 4'b0000);
        tick_exp("abort_reheat", I, H, I, I, 4'b0000);

        // Faults on zone 2 (over-limit while heating), then clear.
        set_temp(2, 300);
        tick_exp("z2_heat", I, H, H, I, 4'b0000);
        set_temp(2, 1290);
        tick_exp("over_abort", I, H, L, I, 4'b0100);
        set_temp(2, 200);
        ticks_exp(9, "fault_lock", I, H, L, I, 4'b0100);
        tick_exp("fault_idle", I, H, I, I, 4'b0100);
        tick_exp("fault_block", I, H, I, I, 4'b0100);
        fault_clr = 1'b1;
        @(posedge clock);
        #1;
        fault_clr = 1'b0;
        expect4("fault_clr", I, H, I, I, 4'b0000);
        check_now();
        tick_exp("post_clr_heat", I, H, H, I, 4'b0000);
        set_temp(3, 1290);
        fault_clr = 1'b1;
        tick_exp("set_wins", I, H, H, I, 4'b1000);
        set_temp(3, 320);
        set_temp(0, 1280);
        tick_exp("tmax_edge", I, H, H, I, 4'b1000);
        set_temp(0, -161);
        tick_exp("under_limit", I, H, H, I, 4'b1001);
        set_temp(0, 320);
        fault_clr = 1'b1;
        @(posedge clock);
        #1;
        fault_clr = 1'b0;
        expect4("clr_all", I, H, H, I, 4'b0000);
        check_now();

        // All four states at once, then asynchronous reset between edges.
        mode = 2'b11;
        set_temp(2, 1290);
        set_temp(3, 340);
        tick_exp("mixed_states", I, H, L, C, 4'b0100);
        #3;
        reset = 1'b1;
        #1;
        expect4("async_reset", I, I, I, I, 4'b0000);
        check_now();
        #1;
        reset = 1'b0;
        set_temp(2, 320);
        set_temp(3, 320);
        @(posedge clock);
        #1;
        expect4("after_release", I, I, I, I, 4'b0000);
        check_now();
        tick_exp("first_tick", I, H, I, I, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
